// File: rtl/div_pkg.sv
// Shared definitions for the iterative DIV/DIVU unit: state encoding and
// default widths.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trial;
  logic           noBorrow;

  // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits and
  // the top bit of the difference is a clean borrow flag.
  assign remShift = {rem, quo[WIDTH-1]};
  assign trial    = remShift - {1'b0, divisor};
  assign noBorrow = ~trial[WIDTH];

  assign remNext = noBorrow ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign quoNext = {quo[WIDTH-2:0], noBorrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage. Produces {HI=remainder,
// LO=quotient}; ready pulses for one cycle when the result is valid.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  divState_e          state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   remR, quoR, divR;
  logic               sgnDiv, sgnA, sgnB;
  logic [2*WIDTH-1:0] resultR;
  logic               accept, lastStep;
  logic               negA, negB;
  logic [WIDTH-1:0]   remStep, quoStep;

  function automatic logic signed [WIDTH-1:0] condNeg(
    input logic signed [WIDTH-1:0] v,
    input logic                    neg
  );
    return neg ? -v : v;
  endfunction

  assign negA = signed_div & opa[WIDTH-1];
  assign negB = signed_div & opb[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (remR),
    .quo     (quoR),
    .divisor (divR),
    .remNext (remStep),
    .quoNext (quoStep)
  );

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = (opb == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        lastStep = (cnt == LAST);
        if (lastStep) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // A flush wins over everything, including a same-cycle accept.
    if (annul) begin
      stateNext = IDLE;
      accept    = 1'b0;
      lastStep  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      remR    <= '0;
      quoR    <= '0;
      divR    <= '0;
      sgnDiv  <= 1'b0;
      sgnA    <= 1'b0;
      sgnB    <= 1'b0;
      resultR <= '0;
    end else if (accept) begin
      cnt    <= '0;
      sgnDiv <= signed_div;
      sgnA   <= negA;
      sgnB   <= negB;
      remR   <= '0;
      quoR   <= condNeg(opa, negA);
      divR   <= condNeg(opb, negB);
      if (opb == '0) resultR <= {opa, {WIDTH{1'b1}}};
    end else if (state == BUSY && !annul) begin
      cnt  <= cnt + 1'b1;
      remR <= remStep;
      quoR <= quoStep;
      // Signs are restored on the final step so DONE presents the final value.
      if (lastStep)
        resultR <= {condNeg(remStep, sgnDiv & sgnA),
                    condNeg(quoStep, sgnDiv & (sgnA ^ sgnB))};
    end
  end

  assign result = resultR;
  assign ready  = (state == DONE);
  assign busy   = (state == BUSY);

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for DIV/DIVU in the execute stage, directly downstream of the decode/execute pipeline register.
- Takes the latched operands from the execute stage and produces a 64-bit {HI=remainder, LO=quotient} result for the hilo write path.
- Holds the pipeline for the duration of the operation. Execute-stage stall logic forms stallE = start & ~ready.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- ITER, WIDTH, number of restoring iterations; fixed equal to WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  a divide instruction occupies execute; level, held until the stage advances.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- annul  in  1  flush/exception in execute; cancels any operation.
- opa  in  WIDTH  dividend; sampled at accept.
- opb  in  WIDTH  divisor; sampled at accept.
- result  out  2*WIDTH  {remainder, quotient}; valid when ready=1, held until the next accept.
- ready  out  1  one-cycle pulse when result is valid.
- busy  out  1  1 while in BUSY.

Behaviour:
- Reset: asynchronous and active-low. Forces state=IDLE, result=0, ready=0, busy=0, counter=0, all operand/partial registers=0. Reset mid-operation abandons the operation with no ready pulse.
- States: IDLE, BUSY, DONE; encoding is in the package.
- IDLE, start=1, annul=0:
  - Accept the operation; latch signed_div, sign(opa), sign(opb), |opa|, |opb|. Absolute values are taken only when signed_div=1.
  - opb != 0: go to BUSY, counter=0.
  - opb == 0: go to DONE. result = {opa, {WIDTH{1'b1}}}, i.e. HI=opa, LO=all ones.
- BUSY:
  - Each cycle performs one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient bit on no-borrow.
  - counter increments each cycle. On counter==ITER-1, the step completes and the state goes to DONE.
- Sign fix on entry to DONE, applied when signed_div=1:
  - quotient negated if sign(opa)^sign(opb).
  - remainder negated if sign(opa).
  - All arithmetic is modulo 2^WIDTH, so 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DONE: ready=1 for exactly this cycle; result is valid. The next state is always IDLE. start is ignored in DONE, so the same instruction is not re-executed.
- Back-to-back divides: if start is still 1 in the IDLE cycle after DONE (next instruction is also a divide), it is accepted normally.
- Latency: accept at cycle 0, BUSY cycles 1..ITER, DONE/ready at cycle ITER+1 (33 for WIDTH=32). Divide-by-zero: ready at cycle 1.
- annul:
  - In any state, forces IDLE on the next edge. No ready pulse; result is unchanged.
  - annul takes priority over start in the same cycle.
  - annul during the DONE cycle still lets that cycle's ready=1 be seen; the state then goes to IDLE.
- start dropping while in BUSY without annul is illegal; the unit ignores it and completes.
- busy = (state==BUSY). ready = (state==DONE) only.

Decomposition:
- Package div_pkg: state enum (IDLE/BUSY/DONE), DIV_WIDTH=32, DIV_CNT_W=$clog2(DIV_WIDTH).
- Sub-module div_step: combinational single restoring iteration. Inputs {rem, quo, divisor}; outputs next {rem, quo}. Instantiated once; the iteration is time-multiplexed.

Test Plan:
- DIVU 100/7 -> ready exactly 33 cycles after the accept cycle; result HI=2, LO=14. busy high for 32 cycles; ready high for exactly 1 cycle.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 -> LO=0xFFFFFFFD, HI=0x00000001. DIVU 0xFFFFFFFF/2 -> LO=0x7FFFFFFF, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> ready at cycle 1; HI=5, LO=0xFFFFFFFF.
- Start 100/7, assert annul at cycle 10 -> IDLE next cycle, no ready, result keeps its prior value. New DIVU 9/3 then -> HI=0, LO=3 after 33 cycles.
- Drive reset=0 at cycle 15 of an operation -> immediately result=0, ready=0, busy=0. After release, start 50/5 -> LO=10, HI=0.
- start held high across DONE, then a second back-to-back divide: the first result is not recomputed. The second is accepted the cycle after ready and its ready arrives 33 cycles later.
